// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: one req/gnt/rvalid data-bus transaction per op,
// with lane steering, load extension, alignment/funct3 checks and a bus timeout.
//
// state | meaning
// IDLE  | ready for a new op (ex_ready=1)
// REQ   | dmem_req held, waiting for gnt
// WAIT  | load granted, waiting for rvalid
// DONE  | result captured; wb_valid issues on the following cycle
module lsu_mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_c,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_idx,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  err_code,
    output logic        lsu_busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       err_q, err_n;
    logic [31:0]      res_q, res_n;
    logic [1:0]       lane_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             ld_q;
    logic             accept, illegal, misal;
    logic [3:0]       be_n;
    logic [31:0]      wdata_n, lane_data, ext_data;

    assign accept = ex_valid && (is_load || is_store);

    // Decode of the presented op: legality, alignment, lane enables and store data.
    always_comb begin
        illegal = is_load ? (funct3 == 3'd3 || funct3[2:1] == 2'b11) : (funct3 > 3'd2);
        misal   = 1'b0;
        be_n    = 4'hF;
        wdata_n = rs2_data;
        case (funct3[1:0])
            2'd0: begin
                be_n    = 4'b0001 << alu_c[1:0];
                wdata_n = {4{rs2_data[7:0]}};
            end
            2'd1: begin
                misal   = alu_c[0];
                be_n    = 4'b0011 << {alu_c[1], 1'b0};
                wdata_n = {2{rs2_data[15:0]}};
            end
            default: misal = (alu_c[1:0] != 2'b00);
        endcase
    end

    // Load lane select and sign/zero extension against the latched address/size.
    always_comb begin
        lane_data = dmem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'd0:    ext_data = {{24{lane_data[7]}}, lane_data[7:0]};
            3'd1:    ext_data = {{16{lane_data[15]}}, lane_data[15:0]};
            3'd2:    ext_data = dmem_rdata;
            3'd4:    ext_data = {24'd0, lane_data[7:0]};
            3'd5:    ext_data = {16'd0, lane_data[15:0]};
            default: ext_data = 32'd0;
        endcase
    end

    // Next-state logic; the timeout check sits ahead of gnt/rvalid so it wins a tie.
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        err_n = err_q;
        res_n = res_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    res_n = 32'd0;
                    cnt_n = '0;
                    if (illegal) begin
                        nxt   = DONE;
                        err_n = 2'd3;
                    end else if (misal) begin
                        nxt   = DONE;
                        err_n = 2'd1;
                    end else begin
                        nxt   = REQ;
                        err_n = 2'd0;
                    end
                end
            end
            REQ: begin
                if (cnt == TMO) begin
                    nxt   = DONE;
                    err_n = 2'd2;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (dmem_gnt) nxt = ld_q ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt == TMO) begin
                    nxt   = DONE;
                    err_n = 2'd2;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (dmem_rvalid) begin
                        nxt   = DONE;
                        res_n = ext_data;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, op context and registered outputs; bus outputs track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            err_q      <= 2'd0;
            res_q      <= 32'd0;
            lane_q     <= 2'd0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            ld_q       <= 1'b0;
            ex_ready   <= 1'b1;
            lsu_busy   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            err_code   <= 2'd0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_n;
            err_q    <= err_n;
            res_q    <= res_n;
            ex_ready <= (nxt == IDLE);
            lsu_busy <= (nxt != IDLE);
            dmem_req <= (nxt == REQ);
            if (state == IDLE && accept) begin
                lane_q <= alu_c[1:0];
                f3_q   <= funct3;
                rd_q   <= rd_idx;
                ld_q   <= is_load;
                if (nxt == REQ) begin
                    dmem_we    <= is_store;
                    dmem_addr  <= {alu_c[31:2], 2'b00};
                    dmem_be    <= be_n;
                    dmem_wdata <= wdata_n;
                end
            end
            wb_valid <= (state == DONE);
            wb_we    <= 1'b0;
            if (state == DONE) begin
                wb_rd    <= rd_q;
                wb_data  <= res_q;
                err_code <= err_q;
                wb_we    <= ld_q && (err_q == 2'd0) && (rd_q != 5'd0);
            end
        end
    end

endmodule
